fifo_wr_arbiter: RTL and testbench

- Shares the write port of the asynchronous FIFO among NREQ requesters in the wclk domain.
- Round-robin arbitration with bounded burst ownership; never pushes while full.
- Drives push/wdata of the FIFO write side directly and observes full.
- Keeps per-requester saturating word counters for bench and debug visibility.

---
 rtl/async_fifo_pkg.sv | 26 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_pkg
//  Description : Shared types and helpers for the async FIFO write-side
//                arbiter: arbiter FSM state type, owner-index width helper
//                and burst counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

    // Arbiter FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Burst counter width; holds MAX_BURST values up to 15.
    localparam int c_burst_cw = 4;

    // Width of a requester index; at least one bit.
    function automatic int owner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority picker. Searches req starting
//                at ptr+1 (modulo NREQ) and returns the first requester found.
//  Ports       : req   - request vector
//                ptr   - last served index; lowest priority this round
//                gnt   - one-hot pick (all zero when no request)
//                idx   - index of the pick
//                valid - a pick was found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ   = 4,
    parameter int OWIDTH = 2
) (
    input  logic [NREQ-1:0]   req,
    input  logic [OWIDTH-1:0] ptr,
    output logic [NREQ-1:0]   gnt,
    output logic [OWIDTH-1:0] idx,
    output logic              valid
);

    int w_cand;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(ptr) + k) % NREQ;
            if (!valid && req[w_cand[OWIDTH-1:0]]) begin
                valid                   = 1'b1;
                gnt[w_cand[OWIDTH-1:0]] = 1'b1;
                idx                     = w_cand[OWIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Shares the async FIFO write port among NREQ requesters with
//                round-robin arbitration and bounded bursts. Never pushes
//                while the FIFO is full. Keeps saturating per-requester
//                accepted-word counters.
//  Ports       : wclk     - write-domain clock
//                reset_L  - synchronous active-low reset
//                req      - per-requester request
//                req_data - flattened request data, DWIDTH per requester
//                gnt      - one-hot acceptance, word pushed same cycle
//                push     - FIFO push
//                wdata    - FIFO write data
//                full     - FIFO full flag
//                owner    - current or last burst owner
//                word_cnt - flattened saturating accepted-word counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int CWIDTH    = 16
) (
    input  logic                          wclk,
    input  logic                          reset_L,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*DWIDTH-1:0]        req_data,
    output logic [NREQ-1:0]               gnt,
    output logic                          push,
    output logic [DWIDTH-1:0]             wdata,
    input  logic                          full,
    output logic [owner_width(NREQ)-1:0]  owner,
    output logic [NREQ*CWIDTH-1:0]        word_cnt
);

    localparam int OWIDTH = owner_width(NREQ);
    localparam logic [c_burst_cw-1:0] c_max_burst = c_burst_cw'(MAX_BURST);
    localparam logic [OWIDTH-1:0]     c_last_idx  = OWIDTH'(NREQ - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_burst_cw-1:0]   r_burst_cnt;
    logic [c_burst_cw-1:0]   w_burst_nxt;
    logic [OWIDTH-1:0]       r_rr_ptr;
    logic [OWIDTH-1:0]       w_rr_nxt;
    logic [OWIDTH-1:0]       r_owner;
    logic [OWIDTH-1:0]       w_owner_nxt;
    logic [NREQ-1:0]         w_gnt;
    logic [DWIDTH-1:0]       w_wdata;

    logic [NREQ-1:0]         w_pick_gnt;
    logic [OWIDTH-1:0]       w_pick_idx;
    logic                    w_pick_valid;

    rr_pick #(
        .NREQ   (NREQ),
        .OWIDTH (OWIDTH)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_rr_ptr),
        .gnt   (w_pick_gnt),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // Grant and next-state decision. Grants are gated by reset so nothing is
    // pushed while the arbiter is held in reset.
    always_comb begin
        w_gnt       = '0;
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        if (reset_L) begin
            case (r_state)
                IDLE: begin
                    if (!full && w_pick_valid) begin
                        w_gnt       = w_pick_gnt;
                        w_owner_nxt = w_pick_idx;
                        w_burst_nxt = c_burst_cw'(1);
                        if (MAX_BURST > 1) begin
                            w_state_nxt = BURST;
                        end else begin
                            w_rr_nxt = w_pick_idx;
                        end
                    end
                end
                BURST: begin
                    // Budget spent or owner released: one bubble cycle while
                    // the owner drops to lowest priority.
                    if ((r_burst_cnt >= c_max_burst) || !req[r_owner]) begin
                        w_rr_nxt    = r_owner;
                        w_state_nxt = IDLE;
                    end else if (!full) begin
                        w_gnt[r_owner] = 1'b1;
                        w_burst_nxt    = r_burst_cnt + c_burst_cw'(1);
                    end
                    // full with req held: stall, keep ownership and budget
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_wdata = w_wdata | req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_rr_ptr    <= c_last_idx;
            r_owner     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_owner     <= w_owner_nxt;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_word_cnt
            logic [CWIDTH-1:0] r_cnt;
            always_ff @(posedge wclk) begin
                if (!reset_L) begin
                    r_cnt <= '0;
                end else if (w_gnt[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CWIDTH'(1);
                end
            end
            assign word_cnt[gi*CWIDTH +: CWIDTH] = r_cnt;
        end
    endgenerate

    assign gnt   = w_gnt;
    assign push  = |w_gnt;
    assign wdata = w_wdata;
    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Directed vectors
//                with literal grant expectations plus a cycle model compared
//                on every falling edge. A second instance with 4-bit counters
//                shares the stimulus to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            wclk = 1'b0;
    logic            reset_L;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic            full;
    logic [NR-1:0]   gnt, gnt_s;
    logic            push, push_s;
    logic [DW-1:0]   wdata, wdata_s;
    logic [1:0]      owner, owner_s;
    logic [NR*16-1:0] word_cnt;
    logic [NR*4-1:0]  word_cnt_s;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NR), .MAX_BURST(MB), .CWIDTH(16)) dut (
        .wclk(wclk), .reset_L(reset_L), .req(req), .req_data(req_data),
        .gnt(gnt), .push(push), .wdata(wdata), .full(full),
        .owner(owner), .word_cnt(word_cnt)
    );

    fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NR), .MAX_BURST(MB), .CWIDTH(4)) dut_s (
        .wclk(wclk), .reset_L(reset_L), .req(req), .req_data(req_data),
        .gnt(gnt_s), .push(push_s), .wdata(wdata_s), .full(full),
        .owner(owner_s), .word_cnt(word_cnt_s)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit in_burst;
    int m_owner, m_cnt, m_rr;
    int m_wc[NR];
    int m_wcs[NR];
    int exp_idx, cand;
    logic [NR-1:0] exp_gnt;
    logic [DW-1:0] exp_wd;

    task automatic model_reset();
        in_burst = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_rr     = NR - 1;
        for (int i = 0; i < NR; i++) begin
            m_wc[i]  = 0;
            m_wcs[i] = 0;
        end
    endtask

    always @(negedge wclk) begin
        if (chk_en) begin
            exp_idx = -1;
            if (reset_L) begin
                if (!in_burst) begin
                    if (!full && req != '0) begin
                        for (int k = 1; k <= NR; k++) begin
                            cand = (m_rr + k) % NR;
                            if (exp_idx < 0 && req[cand]) exp_idx = cand;
                        end
                    end
                end else if (m_cnt < MB && req[m_owner] && !full) begin
                    exp_idx = m_owner;
                end
            end
            exp_gnt = (exp_idx < 0) ? '0 : NR'(1 << exp_idx);
            exp_wd  = (exp_idx < 0) ? '0 : req_data[exp_idx*DW +: DW];

            chk("gnt", 32'(gnt), 32'(exp_gnt));
            chk("push", 32'(push), 32'(exp_idx >= 0));
            chk("wdata", 32'(wdata), 32'(exp_wd));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("gnt_small", 32'(gnt_s), 32'(exp_gnt));
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("word_cnt[%0d]", i), 32'(word_cnt[i*16 +: 16]), 32'(m_wc[i]));
                chk($sformatf("word_cnt_small[%0d]", i), 32'(word_cnt_s[i*4 +: 4]), 32'(m_wcs[i]));
            end
            chk("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
            chk("push_while_full", 32'(push && full), 32'd0);
            chk("gnt_without_req", 32'(gnt & ~req), 32'd0);

            if (!reset_L) begin
                model_reset();
            end else begin
                if (exp_idx >= 0) begin
                    if (m_wc[exp_idx] < 65535) m_wc[exp_idx]++;
                    if (m_wcs[exp_idx] < 15) m_wcs[exp_idx]++;
                end
                if (!in_burst) begin
                    if (exp_idx >= 0) begin
                        m_owner = exp_idx;
                        m_cnt   = 1;
                        if (MB > 1) in_burst = 1'b1;
                        else m_rr = exp_idx;
                    end
                end else if (m_cnt >= MB || !req[m_owner]) begin
                    m_rr     = m_owner;
                    in_burst = 1'b0;
                end else if (!full) begin
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Drive one cycle; exp = requester index, -1 for no grant, -2 for no
    // literal check (model only).
    task automatic apply(input logic [NR-1:0] r, input logic f, input int exp);
        req  = r;
        full = f;
        #2;
        if (exp == -1) begin
            chk("lit_gnt", 32'(gnt), 32'd0);
        end else if (exp >= 0) begin
            chk("lit_gnt", 32'(gnt), 32'(1 << exp));
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        req     = '0;
        full    = 1'b0;
        @(posedge wclk);
        #1;
        reset_L = 1'b1;
    endtask

    int s1[19] = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 2, 2, 2, 2, -1, 3, 3, 3, 3};
    int s2[10] = '{2, 2, 2, 2, -1, 2, 2, 2, 2, -1};

    initial begin
        reset_L  = 1'b0;
        req      = '0;
        full     = 1'b0;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        model_reset();
        @(posedge wclk);
        #1;
        chk_en = 1'b1;
        #2;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_push", 32'(push), 32'd0);
        @(posedge wclk);
        #1;
        chk("reset_word_cnt", 32'(word_cnt[31:0]), 32'd0);
        reset_L = 1'b1;

        // All four requesting: four bursts of four with one bubble between.
        foreach (s1[i]) apply(4'b1111, 1'b0, s1[i]);
        for (int i = 0; i < NR; i++)
            chk($sformatf("s1_word_cnt[%0d]", i), 32'(word_cnt[i*16 +: 16]), 32'd4);

        // Single requester 2: bursts of four separated by a bubble.
        do_reset();
        foreach (s2[i]) apply((i == 9) ? 4'b0000 : 4'b0100, 1'b0, s2[i]);

        // full stall mid-burst of requester 1.
        do_reset();
        apply(4'b0010, 1'b0, 1);
        apply(4'b0010, 1'b0, 1);
        for (int i = 0; i < 3; i++) apply(4'b0011, 1'b1, -1);
        chk("stall_owner", 32'(owner), 32'd1);
        apply(4'b0011, 1'b0, 1);
        apply(4'b0011, 1'b0, 1);
        apply(4'b0011, 1'b0, -1);
        apply(4'b0011, 1'b0, 0);
        chk("after_stall_owner", 32'(owner), 32'd0);
        chk("stall_word_cnt1", 32'(word_cnt[16 +: 16]), 32'd4);

        // Owner 3 drops after one word; bubble then wrap to 0.
        do_reset();
        apply(4'b1000, 1'b0, 3);
        apply(4'b0001, 1'b0, -1);
        req = 4'b0001;
        #2;
        chk("wrap_gnt", 32'(gnt), 32'd1);
        chk("wrap_wdata", 32'(wdata), 32'hA0);
        @(posedge wclk);
        #1;

        // Reset mid-burst with req held.
        do_reset();
        apply(4'b1010, 1'b0, 1);
        apply(4'b1010, 1'b0, 1);
        reset_L = 1'b0;
        #2;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_push", 32'(push), 32'd0);
        @(posedge wclk);
        #1;
        reset_L = 1'b1;
        chk("midrst_word_cnt", 32'(word_cnt[31:0]), 32'd0);
        apply(4'b1010, 1'b0, 1);

        // Saturation: 20 words to requester 0 on 4-bit counters.
        do_reset();
        apply(4'b0001, 1'b1, -1);
        for (int i = 0; i < 25; i++) apply(4'b0001, 1'b0, -2);
        apply(4'b0000, 1'b0, -1);
        chk("sat_small_cnt0", 32'(word_cnt_s[3:0]), 32'd15);
        chk("sat_big_cnt0", 32'(word_cnt[15:0]), 32'd20);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
